alu_n_bit_seq: RTL and testbench
================================

# alu_n_bit_seq

Parametrised, registered N-bit ALU with a Start/Busy/Done handshake. It extends the 4-bit combinational ALU family with the following:
- configurable width;
- registered status flags (carry, zero, negative, overflow);
- iterative multi-cycle unsigned multiply and divide.

It sits between a datapath controller and the register file. The controller issues one operation at a time and consumes the result on Done_Out.

## Interface
- DATA_WIDTH, 8, operand/result width in bits; legal range 4..32.

Ports (clock and reset first):
- Clock_In  input  1  single system clock, rising edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Start_In  input  1  issue request; sampled only while Busy_Out=0.
- Data_A_In  input  DATA_WIDTH  operand A.
- Data_B_In  input  DATA_WIDTH  operand B.
- Carry_Borrowb_In  input  1  carry-in for adds; active-low borrow (1 = no borrow) for subtracts; fill bit for shifts.
- Operation_Select_In  input  4  opcode.
- Busy_Out  output  1  multi-cycle operation in progress.
- Done_Out  output  1  one-cycle pulse; result and flags are updated.
- Result_Out  output  DATA_WIDTH  result; for MUL the low half, for DIV the quotient.
- Result_High_Out  output  DATA_WIDTH  MUL high half or DIV remainder; 0 for all other ops.
- Carry_Out  output  1  carry / no-borrow / shifted-out bit.
- Zero_Out  output  1  result is zero.
- Negative_Out  output  1  MSB of result.
- Overflow_Out  output  1  signed overflow, MUL high half nonzero, or divide-by-zero.

## Operation
Opcodes. Every subtract is computed as A + ~B + c.
- 0x0 ADD: A+B.
- 0x1 ADC: A+B+Cin.
- 0x2 SUB: A-B, with c=1.
- 0x3 SBB: A+~B+Cin.
- 0x4 INC: A+1.
- 0x5 DEC: A+all-ones.
- 0x6 AND, 0x7 OR, 0x8 XOR, 0x9 NOT A.
- 0xA SHL: {A[W-2:0],Cin}; Carry_Out=A[W-1].
- 0xB SHR: {Cin,A[W-1:1]}; Carry_Out=A[0].
- 0xC ASR: {A[W-1],A[W-1:1]}; Carry_Out=A[0].
- 0xD CMP: Result_Out=A; flags are taken from A-B.
- 0xE MUL: unsigned, {Result_High_Out,Result_Out}=A*B; shift-add, one bit per cycle.
- 0xF DIV: unsigned restoring division, one quotient bit per cycle.

Flags:
- Carry_Out:
  - arithmetic ops: bit W of the internal (W+1)-bit sum;
  - subtracts: 1 = no borrow;
  - shifts: the shifted-out bit;
  - logic ops, MUL, DIV: 0.
- Zero_Out:
  - Result_Out==0;
  - MUL: both halves 0;
  - CMP: (A-B)==0.
- Negative_Out: Result_Out[W-1]; for MUL, Result_High_Out[W-1]; for CMP, MSB of A-B.
- Overflow_Out:
  - signed overflow for ops 0x0–0x5 and 0xD;
  - MUL: Result_High_Out!=0;
  - DIV: B==0;
  - all others: 0.

Divide by zero: Result_Out=all-ones, Result_High_Out=A, Overflow_Out=1. This completes with single-cycle timing.

State machine:
- IDLE: Start_In=1 with opcode 0x0–0xD, or DIV with B==0 → load outputs, pulse Done_Out, stay in IDLE.
- IDLE: Start_In=1 with MUL, or DIV with B!=0 → latch A, B and opcode; clear the accumulator; counter=DATA_WIDTH−1; go to RUN.
- RUN: one iteration per cycle.
  - At counter==0 the final iteration completes; load outputs, pulse Done_Out, return to IDLE.
  - Otherwise decrement the counter.

Additional rules:
- Operands are captured at Start. Input changes during RUN are ignored.
- Start_In during RUN is ignored and not queued.
- Result and flag outputs hold their values until the next completed operation.

## Timing
- Reset: asynchronous, takes effect immediately.
  - All outputs go to 0 and state goes to IDLE.
  - Reset during RUN aborts the operation: no Done_Out, outputs cleared.
  - The first Start is accepted on the first rising edge after Reset_In deasserts.
- Single-cycle ops (Start sampled at edge k):
  - outputs valid and Done_Out=1 after edge k+1;
  - Done_Out is low again after edge k+2;
  - Busy_Out stays 0.
- MUL/DIV (Start sampled at edge k):
  - Busy_Out=1 after edges k+1 … k+DATA_WIDTH;
  - after edge k+DATA_WIDTH+1: Busy_Out=0, Done_Out=1, outputs valid.
  - Latency is DATA_WIDTH+1 cycles.
- Back-to-back: Start_In asserted in the Done_Out cycle is accepted, because Busy_Out=0 in that cycle.
- Internal widths:
  - sum is W+1 bits;
  - MUL accumulator is 2W bits;
  - DIV partial remainder is W+1 bits;
  - counter is $clog2(DATA_WIDTH) bits.
  - No truncation warnings are permitted.

## Test plan
All scenarios use DATA_WIDTH=8.
- ADD 0xFF+0x01 → Result 0x00, Carry 1, Zero 1, Overflow 0, Negative 0; Done one cycle after Start, Busy never high.
- SUB 0x80−0x01, then SBB 0x05−0x05 with Cin=0 → first: 0x7F, Carry 1, Overflow 1; second: 0xFF, Carry 0, Negative 1.
- SHL 0x81 with Cin=1 → 0x03, Carry 1. ASR 0x81 → 0xC0, Carry 1, Negative 1.
- MUL 0xFF×0xFF → High 0xFE, Result 0x01, Overflow 1. Busy high for exactly 8 cycles; Done on the 9th.
- DIV 200/7 → quotient 0x1C, remainder 0x04, after 9 cycles. DIV 0x35/0 → 0xFF, remainder 0x35, Overflow 1, after 1 cycle.
- MUL issued:
  - pulse Start_In with ADD during busy cycle 3 → ignored;
  - assert Reset_In asynchronously mid-cycle at busy cycle 4 → all outputs 0 immediately, no Done;
  - after release, ADD 0x02+0x03 → 0x05 with normal timing.

Source files
------------

// File: rtl/alu_n_bit_seq_if.sv
// Controller <-> ALU bundle: operation issue, handshake and result/flags.
// The controller drives the master side, the ALU the slave side.
interface alu_n_bit_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  Start_In;
    logic [DATA_WIDTH-1:0] Data_A_In;
    logic [DATA_WIDTH-1:0] Data_B_In;
    logic                  Carry_Borrowb_In;
    logic [3:0]            Operation_Select_In;
    logic                  Busy_Out;
    logic                  Done_Out;
    logic [DATA_WIDTH-1:0] Result_Out;
    logic [DATA_WIDTH-1:0] Result_High_Out;
    logic                  Carry_Out;
    logic                  Zero_Out;
    logic                  Negative_Out;
    logic                  Overflow_Out;

    modport master (
        output Start_In, Data_A_In, Data_B_In,
        output Carry_Borrowb_In, Operation_Select_In,
        input  Busy_Out, Done_Out, Result_Out, Result_High_Out,
        input  Carry_Out, Zero_Out, Negative_Out, Overflow_Out
    );

    modport slave (
        input  Start_In, Data_A_In, Data_B_In,
        input  Carry_Borrowb_In, Operation_Select_In,
        output Busy_Out, Done_Out, Result_Out, Result_High_Out,
        output Carry_Out, Zero_Out, Negative_Out, Overflow_Out
    );
endinterface

// File: rtl/alu_n_bit_seq.sv
// Registered N-bit ALU with Start/Busy/Done handshake.
// Single-cycle arithmetic/logic/shift; iterative unsigned MUL and DIV.
module alu_n_bit_seq #(
    parameter int DATA_WIDTH = 8
) (
    input logic            Clock_In,
    input logic            Reset_In,
    alu_n_bit_seq_if.slave alu_if
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_ADC = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_SBB = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_DEC = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_NOT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;
    localparam logic [3:0] OP_ASR = 4'hC;
    localparam logic [3:0] OP_CMP = 4'hD;
    localparam logic [3:0] OP_MUL = 4'hE;
    localparam logic [3:0] OP_DIV = 4'hF;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic [2*W-1:0]  acc_q, acc_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    resh_q, resh_d;
    logic            c_q, c_d;
    logic            z_q, z_d;
    logic            n_q, n_d;
    logic            v_q, v_d;
    logic            done_q, done_d;

    logic [W-1:0]    a, b, add_b;
    logic [3:0]      op;
    logic            cin, add_c, add_v;
    logic [W:0]      sum;

    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_acc;
    logic [W:0]      prem, diff;
    logic [2*W-1:0]  div_acc;
    logic [2*W-1:0]  iter_acc;

    // Shared adder: every subtract becomes A + ~B + c
    always_comb begin
        a     = alu_if.Data_A_In;
        b     = alu_if.Data_B_In;
        op    = alu_if.Operation_Select_In;
        cin   = alu_if.Carry_Borrowb_In;
        add_b = b;
        add_c = 1'b0;
        unique case (op)
            OP_ADC: add_c = cin;
            OP_SUB, OP_CMP: begin
                add_b = ~b;
                add_c = 1'b1;
            end
            OP_SBB: begin
                add_b = ~b;
                add_c = cin;
            end
            OP_INC: begin
                add_b = '0;
                add_c = 1'b1;
            end
            OP_DEC: add_b = '1;
            default: ;
        endcase
        sum   = {1'b0, a} + {1'b0, add_b} + {{W{1'b0}}, add_c};
        add_v = (a[W-1] == add_b[W-1]) && (sum[W-1] != a[W-1]);
    end

    // One shift-add or restoring-divide step on the accumulator
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]}
                 + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
        mul_acc  = {mul_sum, acc_q[W-1:1]};
        prem     = acc_q[2*W-1:W-1];
        diff     = prem - {1'b0, opnd_q};
        div_acc  = diff[W] ? {prem[W-1:0], acc_q[W-2:0], 1'b0}
                           : {diff[W-1:0], acc_q[W-2:0], 1'b1};
        iter_acc = is_div_q ? div_acc : mul_acc;
    end

    // Next-state, iteration control and output loading
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        acc_d    = acc_q;
        res_d    = res_q;
        resh_d   = resh_q;
        c_d      = c_q;
        z_d      = z_q;
        n_d      = n_q;
        v_d      = v_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (alu_if.Start_In) begin
                    if (op == OP_MUL || (op == OP_DIV && b != '0)) begin
                        state_d  = RUN;
                        cnt_d    = CNT_INIT;
                        is_div_d = (op == OP_DIV);
                        opnd_d   = (op == OP_DIV) ? b : a;
                        acc_d    = {{W{1'b0}}, ((op == OP_DIV) ? a : b)};
                    end else begin
                        done_d = 1'b1;
                        resh_d = '0;
                        c_d    = 1'b0;
                        v_d    = 1'b0;
                        unique case (op)
                            OP_ADD, OP_ADC, OP_SUB,
                            OP_SBB, OP_INC, OP_DEC: begin
                                res_d = sum[W-1:0];
                                c_d   = sum[W];
                                v_d   = add_v;
                            end
                            OP_AND: res_d = a & b;
                            OP_OR:  res_d = a | b;
                            OP_XOR: res_d = a ^ b;
                            OP_NOT: res_d = ~a;
                            OP_SHL: begin
                                res_d = {a[W-2:0], cin};
                                c_d   = a[W-1];
                            end
                            OP_SHR: begin
                                res_d = {cin, a[W-1:1]};
                                c_d   = a[0];
                            end
                            OP_ASR: begin
                                res_d = {a[W-1], a[W-1:1]};
                                c_d   = a[0];
                            end
                            OP_CMP: begin
                                res_d = a;
                                c_d   = sum[W];
                                v_d   = add_v;
                            end
                            default: begin
                                // divide by zero
                                res_d  = '1;
                                resh_d = a;
                                v_d    = 1'b1;
                            end
                        endcase
                        z_d = (res_d == '0);
                        n_d = res_d[W-1];
                        if (op == OP_CMP) begin
                            z_d = (sum[W-1:0] == '0);
                            n_d = sum[W-1];
                        end
                    end
                end
            end
            RUN: begin
                acc_d = iter_acc;
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    res_d   = iter_acc[W-1:0];
                    resh_d  = iter_acc[2*W-1:W];
                    c_d     = 1'b0;
                    if (is_div_q) begin
                        z_d = (iter_acc[W-1:0] == '0);
                        n_d = iter_acc[W-1];
                        v_d = 1'b0;
                    end else begin
                        z_d = (iter_acc == '0);
                        n_d = iter_acc[2*W-1];
                        v_d = (iter_acc[2*W-1:W] != '0);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any running operation
    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            acc_q    <= '0;
            res_q    <= '0;
            resh_q   <= '0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            v_q      <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            resh_q   <= resh_d;
            c_q      <= c_d;
            z_q      <= z_d;
            n_q      <= n_d;
            v_q      <= v_d;
            done_q   <= done_d;
        end
    end

    assign alu_if.Busy_Out        = (state_q == RUN);
    assign alu_if.Done_Out        = done_q;
    assign alu_if.Result_Out      = res_q;
    assign alu_if.Result_High_Out = resh_q;
    assign alu_if.Carry_Out       = c_q;
    assign alu_if.Zero_Out        = z_q;
    assign alu_if.Negative_Out    = n_q;
    assign alu_if.Overflow_Out    = v_q;
endmodule

// File: tb/tb_alu_n_bit_seq.sv
// Directed bench for alu_n_bit_seq at DATA_WIDTH=8.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_alu_n_bit_seq;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h2, SBB = 4'h3;
    localparam logic [3:0] AND = 4'h6, OR = 4'h7, XOR = 4'h8, NOT = 4'h9;
    localparam logic [3:0] SHL = 4'hA, ASR = 4'hC, CMP = 4'hD;
    localparam logic [3:0] MUL = 4'hE, DIV = 4'hF;

    logic clk = 1'b0;
    logic rst;
    int   errs = 0;
    int   checks = 0;
    int   nb, nc;

    alu_n_bit_seq_if #(.DATA_WIDTH(8)) bus ();

    alu_n_bit_seq #(.DATA_WIDTH(8)) dut (
        .Clock_In (clk),
        .Reset_In (rst),
        .alu_if   (bus)
    );

    always #5 clk = ~clk;

    // {Carry, Zero, Negative, Overflow}
    function automatic logic [3:0] flags();
        return {bus.Carry_Out, bus.Zero_Out, bus.Negative_Out, bus.Overflow_Out};
    endfunction

    task automatic start_op(input logic [3:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic cin);
        bus.Operation_Select_In = op;
        bus.Data_A_In = a;
        bus.Data_B_In = b;
        bus.Carry_Borrowb_In = cin;
        bus.Start_In = 1'b1;
        @(negedge clk);
        bus.Start_In = 1'b0;
    endtask

    // Counts negedges from the first one after Start until Done (bounded)
    task automatic wait_done(output int nbusy, output int ncyc);
        nbusy = 0;
        ncyc = 1;
        while (bus.Done_Out !== 1'b1 && ncyc < 40) begin
            if (bus.Busy_Out === 1'b1) nbusy++;
            @(negedge clk);
            ncyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Start_In = 1'b0;
        bus.Data_A_In = '0;
        bus.Data_B_In = '0;
        bus.Carry_Borrowb_In = 1'b0;
        bus.Operation_Select_In = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.Result_Out, bus.Result_High_Out} !== 16'h0) begin
            errs++;
            $display("FAIL reset_data got %h req 0000",
                     {bus.Result_Out, bus.Result_High_Out});
        end
        checks++;
        if ({bus.Busy_Out, bus.Done_Out, flags()} !== 6'b0) begin
            errs++;
            $display("FAIL reset_ctl got %b req 000000",
                     {bus.Busy_Out, bus.Done_Out, flags()});
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        start_op(ADD, 8'hFF, 8'h01, 1'b0);
        wait_done(nb, nc);
        checks++;
        if (nc !== 1 || nb !== 0) begin
            errs++;
            $display("FAIL add_timing got cyc=%0d busy=%0d req 1 0", nc, nb);
        end
        checks++;
        if (bus.Result_Out !== 8'h00 || bus.Result_High_Out !== 8'h00) begin
            errs++;
            $display("FAIL add_res got %h/%h req 00/00",
                     bus.Result_Out, bus.Result_High_Out);
        end
        checks++;
        if (flags() !== 4'b1100) begin
            errs++;
            $display("FAIL add_flags got %b req 1100", flags());
        end
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b0 || bus.Busy_Out !== 1'b0) begin
            errs++;
            $display("FAIL add_done_pulse got %b%b req 00",
                     bus.Done_Out, bus.Busy_Out);
        end
    endtask

    task automatic test_sub();
        start_op(SUB, 8'h80, 8'h01, 1'b0);
        checks++;
        if ({bus.Done_Out, bus.Result_Out, flags()} !== {1'b1, 8'h7F, 4'b1001}) begin
            errs++;
            $display("FAIL sub got d=%b r=%h f=%b req 1 7f 1001",
                     bus.Done_Out, bus.Result_Out, flags());
        end
        @(negedge clk);
        start_op(SBB, 8'h05, 8'h05, 1'b0);
        checks++;
        if ({bus.Done_Out, bus.Result_Out, flags()} !== {1'b1, 8'hFF, 4'b0010}) begin
            errs++;
            $display("FAIL sbb got d=%b r=%h f=%b req 1 ff 0010",
                     bus.Done_Out, bus.Result_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_shift();
        start_op(SHL, 8'h81, 8'h00, 1'b1);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'h03, 4'b1000}) begin
            errs++;
            $display("FAIL shl got r=%h f=%b req 03 1000",
                     bus.Result_Out, flags());
        end
        @(negedge clk);
        start_op(ASR, 8'h81, 8'h00, 1'b0);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'hC0, 4'b1010}) begin
            errs++;
            $display("FAIL asr got r=%h f=%b req c0 1010",
                     bus.Result_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_logic();
        start_op(AND, 8'hF0, 8'h3C, 1'b1);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'h30, 4'b0000}) begin
            errs++;
            $display("FAIL and got r=%h f=%b req 30 0000", bus.Result_Out, flags());
        end
        start_op(OR, 8'hF0, 8'h3C, 1'b0);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'hFC, 4'b0010}) begin
            errs++;
            $display("FAIL or got r=%h f=%b req fc 0010", bus.Result_Out, flags());
        end
        start_op(NOT, 8'hFF, 8'h00, 1'b0);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'h00, 4'b0100}) begin
            errs++;
            $display("FAIL not got r=%h f=%b req 00 0100", bus.Result_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_cmp();
        start_op(CMP, 8'h05, 8'h05, 1'b0);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'h05, 4'b1100}) begin
            errs++;
            $display("FAIL cmp_eq got r=%h f=%b req 05 1100", bus.Result_Out, flags());
        end
        start_op(CMP, 8'h03, 8'h05, 1'b0);
        checks++;
        if ({bus.Result_Out, flags()} !== {8'h03, 4'b0010}) begin
            errs++;
            $display("FAIL cmp_lt got r=%h f=%b req 03 0010", bus.Result_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_mul();
        start_op(MUL, 8'hFF, 8'hFF, 1'b0);
        wait_done(nb, nc);
        checks++;
        if (nb !== 8 || nc !== 9) begin
            errs++;
            $display("FAIL mul_timing got busy=%0d cyc=%0d req 8 9", nb, nc);
        end
        checks++;
        if ({bus.Busy_Out, bus.Result_High_Out, bus.Result_Out} !== {1'b0, 16'hFE01}) begin
            errs++;
            $display("FAIL mul_res got b=%b %h%h req 0 fe01",
                     bus.Busy_Out, bus.Result_High_Out, bus.Result_Out);
        end
        checks++;
        if (flags() !== 4'b0011) begin
            errs++;
            $display("FAIL mul_flags got %b req 0011", flags());
        end
        @(negedge clk);
        start_op(MUL, 8'h00, 8'h37, 1'b0);
        wait_done(nb, nc);
        checks++;
        if ({bus.Result_High_Out, bus.Result_Out, flags()} !== {16'h0000, 4'b0100}) begin
            errs++;
            $display("FAIL mul_zero got %h%h f=%b req 0000 0100",
                     bus.Result_High_Out, bus.Result_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_div();
        start_op(DIV, 8'd200, 8'd7, 1'b0);
        wait_done(nb, nc);
        checks++;
        if (nb !== 8 || nc !== 9) begin
            errs++;
            $display("FAIL div_timing got busy=%0d cyc=%0d req 8 9", nb, nc);
        end
        checks++;
        if ({bus.Result_Out, bus.Result_High_Out, flags()} !== {8'h1C, 8'h04, 4'b0000}) begin
            errs++;
            $display("FAIL div_res got q=%h r=%h f=%b req 1c 04 0000",
                     bus.Result_Out, bus.Result_High_Out, flags());
        end
        @(negedge clk);
        start_op(DIV, 8'h35, 8'h00, 1'b0);
        wait_done(nb, nc);
        checks++;
        if (nb !== 0 || nc !== 1) begin
            errs++;
            $display("FAIL div0_timing got busy=%0d cyc=%0d req 0 1", nb, nc);
        end
        checks++;
        if ({bus.Result_Out, bus.Result_High_Out, flags()} !== {8'hFF, 8'h35, 4'b0011}) begin
            errs++;
            $display("FAIL div0_res got q=%h r=%h f=%b req ff 35 0011",
                     bus.Result_Out, bus.Result_High_Out, flags());
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        start_op(ADD, 8'h10, 8'h20, 1'b0);
        checks++;
        if ({bus.Done_Out, bus.Result_Out} !== {1'b1, 8'h30}) begin
            errs++;
            $display("FAIL b2b_first got d=%b r=%h req 1 30",
                     bus.Done_Out, bus.Result_Out);
        end
        start_op(XOR, 8'hF0, 8'hFF, 1'b0);
        checks++;
        if ({bus.Done_Out, bus.Result_Out} !== {1'b1, 8'h0F}) begin
            errs++;
            $display("FAIL b2b_second got d=%b r=%h req 1 0f",
                     bus.Done_Out, bus.Result_Out);
        end
        @(negedge clk);
    endtask

    task automatic test_abort();
        start_op(MUL, 8'hFF, 8'hFF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bus.Operation_Select_In = ADD;
        bus.Data_A_In = 8'h01;
        bus.Data_B_In = 8'h01;
        bus.Start_In = 1'b1;
        @(negedge clk);
        bus.Start_In = 1'b0;
        checks++;
        if ({bus.Busy_Out, bus.Done_Out, bus.Result_Out} !== {2'b10, 8'h0F}) begin
            errs++;
            $display("FAIL abort_ignore got b=%b d=%b r=%h req 1 0 0f",
                     bus.Busy_Out, bus.Done_Out, bus.Result_Out);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.Busy_Out, bus.Done_Out, bus.Result_Out,
             bus.Result_High_Out, flags()} !== 22'h0) begin
            errs++;
            $display("FAIL abort_clear got b=%b d=%b r=%h h=%h f=%b req all 0",
                     bus.Busy_Out, bus.Done_Out, bus.Result_Out,
                     bus.Result_High_Out, flags());
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.Done_Out !== 1'b0) begin
            errs++;
            $display("FAIL abort_no_done got %b req 0", bus.Done_Out);
        end
        rst = 1'b0;
        start_op(ADD, 8'h02, 8'h03, 1'b0);
        checks++;
        if ({bus.Done_Out, bus.Busy_Out, bus.Result_Out} !== {2'b10, 8'h05}) begin
            errs++;
            $display("FAIL post_reset_add got d=%b b=%b r=%h req 1 0 05",
                     bus.Done_Out, bus.Busy_Out, bus.Result_Out);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shift();
        test_logic();
        test_cmp();
        test_mul();
        test_div();
        test_back_to_back();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
